// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR random word generator
package lfsr_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        VALID = 1'b1
    } lfsr_fsm_t;

    // Maximal-length Galois feedback masks
    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [15:0] TAPS16 = 16'hB400;
    localparam logic [31:0] TAPS32 = 32'hA3000000;

    localparam logic [15:0] DEFAULT_SEED16 = 16'hACE1;

endpackage

// File: rtl/lfsr_rng_if.sv
// rtl/lfsr_rng_if.sv - valid/ready word stream between the generator and its consumer
interface lfsr_rng_if #(
    parameter int unsigned OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Galois LFSR state register with seed load and zero-state protection
module lfsr_core #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             bit_o,
    output logic             seed_fix_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             seed_fix_q, seed_fix_d;

    // Next state: load beats everything, a zero state self-heals, otherwise step when asked
    always_comb begin
        state_d    = state_q;
        seed_fix_d = 1'b0;
        if (load_i) begin
            if (seed_i == '0) begin
                state_d    = DEFAULT_SEED;
                seed_fix_d = 1'b1;
            end else begin
                state_d = seed_i;
            end
        end else if (state_q == '0) begin
            state_d = DEFAULT_SEED;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    // State and seed-fix pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DEFAULT_SEED;
            seed_fix_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_fix_q <= seed_fix_d;
        end
    end

    // The all-zero state must never be entered
    a_state_nonzero: assert property (@(posedge clk) disable iff (!rst_n) state_q != '0);

    assign state_o    = state_q;
    assign bit_o      = state_q[0];
    assign seed_fix_o = seed_fix_q;

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - pseudo-random word generator: collects LFSR bits into words on a valid/ready stream
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED16,
    parameter int unsigned      OUT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   seed_i,
    output logic [WIDTH-1:0]   state_o,
    output logic               seed_fix_o,
    lfsr_rng_if.master         out_if
);

    localparam int unsigned      CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    lfsr_fsm_t        fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] word_q, word_d, word_nxt;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             step;
    logic             core_bit;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (step),
        .load_i     (load_i),
        .seed_i     (seed_i),
        .state_o    (state_o),
        .bit_o      (core_bit),
        .seed_fix_o (seed_fix_o)
    );

    // FSM next state, word assembly and handshake; load discards any partial or pending word
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        step        = 1'b0;
        word_nxt    = word_q;
        word_nxt[cnt_q] = core_bit;
        if (load_i) begin
            fsm_d       = FILL;
            cnt_d       = '0;
            word_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            case (fsm_q)
                FILL: begin
                    if (en_i) begin
                        step = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            out_data_d  = word_nxt;
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            word_d      = '0;
                            fsm_d       = VALID;
                        end else begin
                            word_d = word_nxt;
                            cnt_d  = cnt_q + 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (out_if.out_ready) begin
                        out_valid_d = 1'b0;
                        fsm_d       = FILL;
                    end
                end
                default: fsm_d = FILL;
            endcase
        end
    end

    // FSM, counter, partial word and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= FILL;
            cnt_q       <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - scoreboard testbench for lfsr_rng with directed vectors
module tb_lfsr_rng;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en_i   = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] seed_i = 16'h0000;
    logic [15:0] state_o;
    logic        seed_fix_o;

    lfsr_rng_if #(.OUT_W(8)) bus ();

    lfsr_rng #(
        .WIDTH        (16),
        .TAPS         (16'hB400),
        .DEFAULT_SEED (16'hACE1),
        .OUT_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .load_i     (load_i),
        .seed_i     (seed_i),
        .state_o    (state_o),
        .seed_fix_o (seed_fix_o),
        .out_if     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] st;
    } exp_t;

    exp_t exp_q[$];
    logic seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(name, n, exp_edges);
    endtask

    // Monitor: compare each newly presented word against the scoreboard, count accepted words
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", {24'h0, bus.out_data}, {24'h0, e.data});
                    chk("word_state", {16'h0, state_o}, {16'h0, e.st});
                end
            end else if (!bus.out_valid) begin
                seen = 1'b0;
            end
            if (bus.out_valid && bus.out_ready && !load_i) consumed++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        bad;
        logic [15:0] prev;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_state", {16'h0, state_o}, 32'h0000_ACE1);
        chk("reset_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("reset_data", {24'h0, bus.out_data}, 32'h0);
        chk("reset_seed_fix", {31'h0, seed_fix_o}, 32'h0);
        tick();
        rst_n = 1'b1;

        // 1: first word after reset, then hold with out_ready low
        exp_q.push_back('{data: 8'hE1, st: 16'hC2C4});
        en_i = 1'b1;
        wait_valid("t1_latency", 8);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.out_valid || bus.out_data !== 8'hE1 || state_o !== 16'hC2C4) bad = 1'b1;
        end
        chk("t1_hold20", {31'h0, bad}, 32'h0);

        // 2: consume, then the next word
        exp_q.push_back('{data: 8'hC4, st: 16'hEB62});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t2_valid_drop", {31'h0, bus.out_valid}, 32'h0);
        wait_valid("t2_latency", 8);

        // 3: zero seed substitution
        en_i   = 1'b0;
        load_i = 1'b1;
        seed_i = 16'h0000;
        tick();
        load_i = 1'b0;
        chk("t3_seed_fix_pulse", {31'h0, seed_fix_o}, 32'h1);
        chk("t3_state", {16'h0, state_o}, 32'h0000_ACE1);
        chk("t3_valid_cleared", {31'h0, bus.out_valid}, 32'h0);
        tick();
        chk("t3_seed_fix_gone", {31'h0, seed_fix_o}, 32'h0);
        exp_q.push_back('{data: 8'hE1, st: 16'hC2C4});
        en_i = 1'b1;
        wait_valid("t3_latency", 8);

        // 4: load mid-fill discards the partial word
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t4_state_3steps", {16'h0, state_o}, 32'h0000_AC58);
        load_i = 1'b1;
        seed_i = 16'hACE1;
        tick();
        load_i = 1'b0;
        chk("t4_state_loaded", {16'h0, state_o}, 32'h0000_ACE1);
        chk("t4_no_seed_fix", {31'h0, seed_fix_o}, 32'h0);
        exp_q.push_back('{data: 8'hE1, st: 16'hC2C4});
        wait_valid("t4_latency", 8);

        // 5: en toggling during fill
        en_i   = 1'b0;
        load_i = 1'b1;
        seed_i = 16'hACE1;
        tick();
        load_i = 1'b0;
        exp_q.push_back('{data: 8'hE1, st: 16'hC2C4});
        bad = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            en_i = (i % 2 == 0);
            prev = state_o;
            tick();
            if (!en_i && state_o !== prev) bad = 1'b1;
            if (i < 16 && bus.out_valid) bad = 1'b1;
        end
        chk("t5_pause_hold", {31'h0, bad}, 32'h0);
        chk("t5_valid_at16", {31'h0, bus.out_valid}, 32'h1);

        // 6: load and out_ready together in VALID
        en_i          = 1'b0;
        load_i        = 1'b1;
        bus.out_ready = 1'b1;
        seed_i        = 16'h1234;
        tick();
        load_i        = 1'b0;
        bus.out_ready = 1'b0;
        chk("t6_valid_cleared", {31'h0, bus.out_valid}, 32'h0);
        chk("t6_state", {16'h0, state_o}, 32'h0000_1234);
        chk("t6_consumed", consumed, 2);

        // Asynchronous reset mid-fill
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_state", {16'h0, state_o}, 32'h0000_ACE1);
        chk("rst_async_data", {24'h0, bus.out_data}, 32'h0);
        tick();
        exp_q.push_back('{data: 8'hE1, st: 16'hC2C4});
        rst_n = 1'b1;
        wait_valid("rst_latency", 8);
        tick();

        chk("queue_empty", exp_q.size(), 0);
        chk("consumed_final", consumed, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Galois LFSR pseudo-random word generator for the 50 MHz game/graphics datapath.
- Replaces the fixed 8-bit LFSR with configurable width, tap polynomial and output word size.
- Adds seed loading with all-zero lock-up protection and a valid/ready output stream.
- Collects one pseudo-random bit per enabled clock into an OUT_W-bit word for downstream consumers (sprite placement, noise, timers).

Parameters:
- WIDTH, 16, LFSR state width; must be >= 2.
- TAPS, 16'hB400, Galois feedback mask, WIDTH bits; the default is x^16+x^14+x^13+x^11+1, maximal length.
- DEFAULT_SEED, 16'hACE1, state after reset and substitute for a zero seed; must be non-zero.
- OUT_W, 8, bits per output word; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- en  input  1  advance enable; 0 pauses filling
- load  input  1  load seed this cycle; highest priority after reset
- seed  input  WIDTH  seed value sampled when load=1
- out_ready  input  1  consumer accepts out_data
- out_valid  output  1  out_data holds a complete word
- out_data  output  OUT_W  random word, first generated bit in bit 0
- state  output  WIDTH  current LFSR register, for debug
- seed_fix  output  1  one-cycle pulse: zero seed was replaced by DEFAULT_SEED

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is clk.
- Reset values: state=DEFAULT_SEED, out_valid=0, out_data=0, seed_fix=0, bit count=0, FSM=FILL.
- Galois step: b=state[0]; next=(state>>1) ^ (b ? TAPS : 0). The generated bit is b, the value before the step.
- FSM FILL, one edge per step, when en=1 and load=0:
  - step the LFSR;
  - shift b into the word: bit k of the word = k-th bit generated since the fill started;
  - count++.
  - On the edge where count reaches OUT_W: out_data<=assembled word, out_valid<=1, count<=0, go to VALID.
  - With en=1 continuously, out_valid rises OUT_W edges after entering FILL.
- FSM VALID:
  - LFSR frozen; out_data and out_valid held stable regardless of en.
  - On an edge with out_valid&out_ready: out_valid<=0, go to FILL. No LFSR step on that edge.
  - Maximum throughput is one word per OUT_W+1 cycles.
- en=0 in FILL: no step, count and partial word hold.
- load=1, any state:
  - state<=seed, or DEFAULT_SEED with seed_fix<=1 when seed==0;
  - partial word and count cleared; out_valid<=0, so a pending word is discarded even if out_ready=1 that cycle;
  - FSM<=FILL; en is ignored that cycle.
- seed_fix is 0 on every edge that does not load a zero seed.
- The all-zero state is unreachable by construction. The implementation additionally forces DEFAULT_SEED if state==0 is ever detected; this is an assertion target.
- Reset mid-fill or mid-VALID returns all registers to their reset values immediately; no partial word survives.
- OUT_W > WIDTH is legal. Bits simply continue across the LFSR period.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum {FILL, VALID} lfsr_fsm_t;
  - constants for maximal-length taps at widths 8, 16 and 32: TAPS8=8'hB8, TAPS16=16'hB400, TAPS32=32'hA3000000;
  - DEFAULT_SEED16=16'hACE1.
- Sub-module lfsr_core, parametrised WIDTH/TAPS/DEFAULT_SEED: state register, Galois step, load and zero-seed substitution. It outputs state and bit b.
- lfsr_rng owns the FSM, counter, word assembly and handshake.

Test Plan:
1. Reset, en=1, out_ready=0, default parameters -> out_valid rises after 8 edges with out_data=8'hE1, state=16'hC2C4. out_data then holds for 20 cycles.
2. From test 1, pulse out_ready=1 for one cycle -> out_valid drops. After 8 more en edges: out_data=8'hC4, state=16'hEB62.
3. load=1, seed=16'h0000 -> seed_fix pulses for exactly 1 cycle, state=16'hACE1. The next word is 8'hE1.
4. Mid-fill after 3 steps, assert load with seed=16'hACE1 -> partial word discarded. The next out_valid comes 8 en-edges later with 8'hE1.
5. Toggle en 0/1 every cycle during FILL -> out_valid after 16 cycles, still 8'hE1. state is unchanged on en=0 edges.
6. In VALID, assert load and out_ready together with seed=16'h1234 -> out_valid=0 next cycle, state=16'h1234. The old word is not counted as consumed by the scoreboard.
